// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Conditions a raw, bouncing push-button into a clean debounced level and a
// one-cycle step strobe, with optional auto-repeat while the button is held.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active-low
//   button_in  in   raw push-button, active-high, asynchronous, may bounce
//   repeat_en  in   auto-repeat enable, synchronous to clk
//   btn_level  out  debounced button state (registered)
//   btn_pulse  out  one-cycle step strobe (registered)
//   fsm_state  out  current FSM state encoding, for observation only
//
// Handshake: none. btn_pulse is a plain one-cycle strobe with no ready; a
// downstream consumer must sample it on every rising edge of clk.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned REPEAT_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_in,
  input  logic       repeat_en,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_e;

  // Terminal counts: each state counts 0..LIMIT-1 and acts on the last value,
  // so the counter never reaches its limit and never wraps.
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);

  logic        sync1_q, sync2_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        pulse_q, pulse_d;
  logic        s;

  // Second synchronizer flop is the only view of the button the FSM gets.
  assign s = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= button_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        cnt_d   = 16'd0;
        if (s) begin
          state_d = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = 16'd0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 16'd0;
        end else if (!repeat_en) begin
          // Hold timer only runs while auto-repeat is enabled.
          cnt_d = 16'd0;
        end else if (cnt_q == HLD_LAST) begin
          state_d = REPEAT;
          cnt_d   = 16'd0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      REPEAT: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 16'd0;
        end else if (!repeat_en) begin
          state_d = PRESSED;
          cnt_d   = 16'd0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d   = 16'd0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RELEASE_WAIT: begin
        // Level stays high until the release is confirmed; a bounce back to
        // high returns to PRESSED silently and restarts the hold timer.
        if (s) begin
          state_d = PRESSED;
          cnt_d   = 16'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign fsm_state = state_q;

endmodule
